// File: rtl/imem_loader.sv
// imem_loader: byte-serial program loader for the instruction memory.
// Receives a 16-bit big-endian word-count header followed by big-endian
// instruction bytes on a valid/ready stream. It packs the bytes into words and
// writes them at ADDR_BASE + 4*index. The CPU is held in reset until a load
// completes successfully.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte (covering the header and data bytes) before DONE.
module imem_loader #(
  parameter int unsigned   n         = 32,
  parameter logic [n-1:0]  ADDR_BASE = '0,
  parameter int unsigned   MAX_WORDS = 256
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [n-1:0]  imem_addr,
  output logic [n-1:0]  imem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   words_loaded
);

  localparam int unsigned LEN_W   = 16;
  localparam int unsigned WORD_W  = 32;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd6;
  // State entered once the last word is written (or for an empty load)
  localparam logic [2:0] S_TAIL  = S_CHK;
`else
  localparam logic [2:0] S_TAIL  = S_DONE;
`endif

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]  index_q, index_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]  words_d;
  logic [n-1:0]      addr_d;
  logic [n-1:0]      wdata_d;
  logic              we_d;
  logic              ready_d;
  logic              busy_d;
  logic              done_d;
  logic              err_d;
  logic              hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic              xfer_c;
  logic [LEN_W-1:0]  hdr_len_c;

  // A byte moves on any edge where the stream is valid and we are ready
  assign xfer_c    = byte_valid & byte_ready;
  assign hdr_len_c = {len_q[15:8], byte_data};

  // Next-state and next-output logic; outputs are registered from state_d
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    index_d    = index_q;
    len_d      = len_q;
    shift_d    = shift_q;
    words_d    = words_loaded;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_HDR;
          byte_cnt_d = 2'd0;
          index_d    = '0;
          words_d    = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d      = 8'h00;
`endif
        end
      end

      S_HDR: begin
        if (xfer_c) begin
`ifdef LOADER_CHECKSUM_EN
          chk_d = chk_q ^ byte_data;
`endif
          if (byte_cnt_q == 2'd0) begin
            len_d      = {byte_data, 8'h00};
            byte_cnt_d = 2'd1;
          end else begin
            len_d      = hdr_len_c;
            byte_cnt_d = 2'd0;
            if (hdr_len_c == '0) begin
              state_d = S_TAIL;
            end else if (hdr_len_c > MAX_LEN) begin
              state_d = S_ERROR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (xfer_c) begin
`ifdef LOADER_CHECKSUM_EN
          chk_d = chk_q ^ byte_data;
`endif
          shift_d = {shift_q[23:0], byte_data};
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = S_WRITE;
            addr_d     = ADDR_BASE + (n'(index_q) << 2);
            wdata_d    = n'(shift_d);
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        index_d = index_q + 16'd1;
        words_d = words_loaded + 16'd1;
        if (index_d == len_q) begin
          state_d = S_TAIL;
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer_c) begin
          state_d = (byte_data == chk_q) ? S_DONE : S_ERROR;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    we_d    = (state_d == S_WRITE);
    ready_d = (state_d == S_HDR) || (state_d == S_DATA);
    busy_d  = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_WRITE);
`ifdef LOADER_CHECKSUM_EN
    ready_d = ready_d || (state_d == S_CHK);
    busy_d  = busy_d  || (state_d == S_CHK);
`endif
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERROR);
    hold_d  = (state_d != S_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      index_q      <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= ADDR_BASE;
      imem_wdata   <= '0;
      byte_ready   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_hold     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      index_q      <= index_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      words_loaded <= words_d;
      imem_we      <= we_d;
      imem_addr    <= addr_d;
      imem_wdata   <= wdata_d;
      byte_ready   <= ready_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      cpu_hold     <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

endmodule
